// File: rtl/cond_exec_stage.sv
// Decode->Execute pipeline register with ARM conditional execution: holds the NZCV
// flag register, evaluates the E-stage condition and gates side-effecting controls.
module cond_exec_stage #(
   parameter logic [3:0] FLAGS_RESET = 4'b0000,
   parameter logic       NV_EXECUTES = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       StallE,
   input  logic       FlushE,
   input  logic [3:0] CondD,
   input  logic       PCSrcD,
   input  logic       RegWriteD,
   input  logic       MemWriteD,
   input  logic       MemtoRegD,
   input  logic       ALUSrcD,
   input  logic       branchD,
   input  logic       blwriteD,
   input  logic       blselD,
   input  logic [3:0] ALUControlD,
   input  logic [1:0] FlagWriteD,
   input  logic [1:0] ShiftControlD,
   input  logic [4:0] shamtD,
   input  logic [3:0] ALUFlags,
   output logic       PCSrcE,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       BranchTakenE,
   output logic       blwriteE,
   output logic       MemtoRegE,
   output logic       ALUSrcE,
   output logic       blselE,
   output logic [3:0] ALUControlE,
   output logic [1:0] ShiftControlE,
   output logic [4:0] shamtE,
   output logic       CondExE,
   output logic [3:0] FlagsE
);

   typedef struct packed {
      logic       pcsrc;
      logic       regwrite;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       branch;
      logic       blwrite;
      logic       blsel;
      logic [3:0] alucontrol;
      logic [1:0] flagwrite;
      logic [1:0] shiftcontrol;
      logic [4:0] shamt;
      logic [3:0] cond;
   } e_reg_t;

   e_reg_t     e_d, e_q;
   logic [3:0] flags_d, flags_q;
   logic       n, z, c, v;
   logic       cond_ex;

   assign {n, z, c, v} = flags_q;

   // Condition is judged against the flags as they stood before this instruction writes them.
   always_comb begin
      cond_ex = 1'b0;
      case (e_q.cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = NV_EXECUTES;
      endcase
   end

   always_comb begin
      e_d = e_q;
      if (FlushE) begin
         e_d      = '0;
         e_d.cond = 4'b1110;
      end else if (!StallE) begin
         e_d = '{pcsrc: PCSrcD, regwrite: RegWriteD, memwrite: MemWriteD,
                 memtoreg: MemtoRegD, alusrc: ALUSrcD, branch: branchD,
                 blwrite: blwriteD, blsel: blselD, alucontrol: ALUControlD,
                 flagwrite: FlagWriteD, shiftcontrol: ShiftControlD,
                 shamt: shamtD, cond: CondD};
      end
   end

   // A flush still retires the leaving instruction's flag write; a stall does not.
   always_comb begin
      flags_d = flags_q;
      if (!StallE && cond_ex) begin
         if (e_q.flagwrite[0]) flags_d[3:2] = ALUFlags[3:2];
         if (e_q.flagwrite[1]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q     <= '0;
         flags_q <= FLAGS_RESET;
      end else begin
         e_q     <= e_d;
         flags_q <= flags_d;
      end
   end

   assign PCSrcE        = e_q.pcsrc & cond_ex;
   assign RegWriteE     = e_q.regwrite & cond_ex;
   assign MemWriteE     = e_q.memwrite & cond_ex;
   assign BranchTakenE  = e_q.branch & cond_ex;
   assign blwriteE      = e_q.blwrite & cond_ex;
   assign MemtoRegE     = e_q.memtoreg;
   assign ALUSrcE       = e_q.alusrc;
   assign blselE        = e_q.blsel;
   assign ALUControlE   = e_q.alucontrol;
   assign ShiftControlE = e_q.shiftcontrol;
   assign shamtE        = e_q.shamt;
   assign CondExE       = cond_ex;
   assign FlagsE        = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed scenarios plus random traffic checked against
// an instruction-level model of the E register, NZCV flags and ARM condition rules.
module tb_cond_exec_stage;

   localparam logic [3:0] FLAGS_RESET = 4'b0000;
   localparam logic       NV_EXECUTES = 1'b0;
   localparam int         W = 24;

   typedef struct packed {
      logic       pcsrc;
      logic       regwrite;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       branch;
      logic       blwrite;
      logic       blsel;
      logic [3:0] aluc;
      logic [1:0] fw;
      logic [1:0] sc;
      logic [4:0] shamt;
      logic [3:0] cond;
   } instr_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   instr_t     in_d;
   logic       stall, flush;
   logic [3:0] alu_flags;

   logic       PCSrcE, RegWriteE, MemWriteE, BranchTakenE, blwriteE;
   logic       MemtoRegE, ALUSrcE, blselE, CondExE;
   logic [3:0] ALUControlE, FlagsE;
   logic [1:0] ShiftControlE;
   logic [4:0] shamtE;

   cond_exec_stage #(.FLAGS_RESET(FLAGS_RESET), .NV_EXECUTES(NV_EXECUTES)) dut (
      .clk(clk), .reset_n(reset_n), .StallE(stall), .FlushE(flush),
      .CondD(in_d.cond), .PCSrcD(in_d.pcsrc), .RegWriteD(in_d.regwrite),
      .MemWriteD(in_d.memwrite), .MemtoRegD(in_d.memtoreg), .ALUSrcD(in_d.alusrc),
      .branchD(in_d.branch), .blwriteD(in_d.blwrite), .blselD(in_d.blsel),
      .ALUControlD(in_d.aluc), .FlagWriteD(in_d.fw), .ShiftControlD(in_d.sc),
      .shamtD(in_d.shamt), .ALUFlags(alu_flags),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .BranchTakenE(BranchTakenE), .blwriteE(blwriteE), .MemtoRegE(MemtoRegE),
      .ALUSrcE(ALUSrcE), .blselE(blselE), .ALUControlE(ALUControlE),
      .ShiftControlE(ShiftControlE), .shamtE(shamtE), .CondExE(CondExE),
      .FlagsE(FlagsE)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   instr_t     m_e;
   logic [3:0] m_flags;

   // ARM rule: cond[3:1] picks a base test, cond[0] inverts it (AL/NV special).
   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
      logic fn, fz, fc, fv, base;
      {fn, fz, fc, fv} = f;
      if (cc == 4'b1111) return NV_EXECUTES;
      case (cc[3:1])
         3'd0:    base = fz;
         3'd1:    base = fc;
         3'd2:    base = fn;
         3'd3:    base = fv;
         3'd4:    base = fc && !fz;
         3'd5:    base = (fn == fv);
         3'd6:    base = (fn == fv) && !fz;
         default: base = 1'b1;
      endcase
      return cc[0] ? !base : base;
   endfunction

   function automatic logic [W-1:0] model_outs();
      logic cx;
      cx = cond_pass(m_e.cond, m_flags);
      return {m_e.pcsrc & cx, m_e.regwrite & cx, m_e.memwrite & cx, m_e.branch & cx,
              m_e.blwrite & cx, m_e.memtoreg, m_e.alusrc, m_e.blsel, m_e.aluc, m_e.sc,
              m_e.shamt, cx, m_flags};
   endfunction

   function automatic logic [W-1:0] dut_outs();
      return {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, blwriteE, MemtoRegE, ALUSrcE,
              blselE, ALUControlE, ShiftControlE, shamtE, CondExE, FlagsE};
   endfunction

   task automatic model_reset();
      m_e     = '0;
      m_flags = FLAGS_RESET;
   endtask

   task automatic model_edge();
      logic cx;
      cx = cond_pass(m_e.cond, m_flags);
      if (!stall && cx) begin
         if (m_e.fw[0]) m_flags[3:2] = alu_flags[3:2];
         if (m_e.fw[1]) m_flags[1:0] = alu_flags[1:0];
      end
      if (flush) begin
         m_e      = '0;
         m_e.cond = 4'b1110;
      end else if (!stall) begin
         m_e = in_d;
      end
   endtask

   task automatic sb_check(input string tag);
      logic [W-1:0] e;
      exp_q.push_back(model_outs());
      e = exp_q.pop_front();
      check(tag, {8'h0, dut_outs()}, {8'h0, e});
   endtask

   // ---------------- driver tasks ----------------
   function automatic instr_t mk(input logic [3:0] cc, input logic [1:0] fw);
      instr_t t;
      t      = '0;
      t.cond = cc;
      t.fw   = fw;
      return t;
   endfunction

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      sb_check(tag);
   endtask

   task automatic rand_drive();
      in_d      = instr_t'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      alu_flags = 4'($urandom_range(0, 15));
   endtask

   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      sb_check("async_reset");
      check("async_reset_flags", {28'h0, FlagsE}, {28'h0, FLAGS_RESET});
      #2;
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_d      = '0;
      stall     = 1'b0;
      flush     = 1'b0;
      alu_flags = 4'h0;
      model_reset();
      #2;
      sb_check("reset_state");
      check("reset_condex", {31'h0, CondExE}, {31'h0, cond_pass(4'b0000, FLAGS_RESET)});
      @(negedge clk);
      reset_n = 1'b1;

      // ADDS sets flags one edge after it reaches E
      in_d = mk(4'b1110, 2'b11);
      cycle("adds_load");
      check("adds_condex", {31'h0, CondExE}, 32'h1);
      in_d = mk(4'b1110, 2'b00);
      alu_flags = 4'b0110;
      cycle("adds_flag");
      check("adds_flags", {28'h0, FlagsE}, 32'h6);

      // MOVNE with Z=1 must not write registers or flags
      in_d = mk(4'b0001, 2'b01);
      in_d.regwrite = 1'b1;
      cycle("movne_load");
      check("movne_regwrite", {31'h0, RegWriteE}, 32'h0);
      check("movne_condex", {31'h0, CondExE}, 32'h0);
      in_d = mk(4'b1110, 2'b00);
      alu_flags = 4'b1000;
      cycle("movne_flag");
      check("movne_flags", {28'h0, FlagsE}, 32'h6);

      // Set N=1,V=0 then BLT / BGE
      in_d = mk(4'b1110, 2'b11);
      cycle("setn_load");
      in_d = mk(4'b1011, 2'b00);
      in_d.branch = 1'b1;
      in_d.blwrite = 1'b1;
      cycle("blt_load");
      check("blt_flags", {28'h0, FlagsE}, 32'h8);
      check("blt_taken", {30'h0, BranchTakenE, blwriteE}, 32'h3);
      in_d.cond = 4'b1010;
      cycle("bge_load");
      check("bge_taken", {30'h0, BranchTakenE, blwriteE}, 32'h0);

      // SUBS held for three cycles; flags change only on release
      in_d = mk(4'b1110, 2'b11);
      in_d.aluc = 4'h2;
      cycle("subs_load");
      in_d = mk(4'b1110, 2'b00);
      stall = 1'b1;
      alu_flags = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         cycle("subs_stall");
         check("subs_stall_flags", {28'h0, FlagsE}, 32'h8);
         check("subs_stall_aluc", {28'h0, ALUControlE}, 32'h2);
      end
      stall = 1'b0;
      cycle("subs_release");
      check("subs_release_flags", {28'h0, FlagsE}, 32'h4);

      // Flush beats stall: bubble loads as AL
      in_d = mk(4'b1110, 2'b11);
      in_d.regwrite = 1'b1;
      cycle("pre_flush_load");
      stall = 1'b1;
      flush = 1'b1;
      alu_flags = 4'b1111;
      cycle("flush_stall");
      check("flush_condex", {31'h0, CondExE}, 32'h1);
      check("flush_gated", {27'h0, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, blwriteE}, 32'h0);
      stall = 1'b0;
      flush = 1'b0;
      in_d = mk(4'b1110, 2'b00);
      cycle("post_flush");
      check("post_flush_flags", {28'h0, FlagsE}, 32'h4);

      // NV never executes here
      in_d = mk(4'b1111, 2'b11);
      in_d.regwrite = 1'b1;
      cycle("nv_load");
      check("nv_condex", {31'h0, CondExE}, {31'h0, NV_EXECUTES});

      // Random traffic with an asynchronous reset in the middle
      for (int i = 0; i < 400; i++) begin
         rand_drive();
         cycle("rand");
         if (i == 200) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
